// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - carry-save pair to binary resolver, one CHUNK-bit slice per clock
//
// Computes Sum_out = S_in + 2*C_in by rippling a (CHUNK+1)-bit add over
// NUM_CHUNKS slices, one slice per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   S_in/C_in valid
//   in_ready   block can accept a new pair (registered)
//   S_in       carry-save sum vector, BIT_LEN bits
//   C_in       carry-save carry vector, weight 2, BIT_LEN bits
//   out_valid  Sum_out holds a resolved result (registered)
//   out_ready  downstream accepts the result
//   Sum_out    resolved result, BIT_LEN+2 bits

module csa_resolver #(
   parameter int BIT_LEN = 19,
   parameter int CHUNK   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIT_LEN-1:0] S_in,
   input  logic [BIT_LEN-1:0] C_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BIT_LEN+1:0] Sum_out
);

   localparam int W          = BIT_LEN + 2;
   localparam int NUM_CHUNKS = (W + CHUNK - 1) / CHUNK;
   localparam int PW         = NUM_CHUNKS * CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int PW_W       = $clog2(PW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic              carry;
   logic [PW-1:0]     x_reg;
   logic [PW-1:0]     y_reg;
   logic [PW-1:0]     res_reg;

   logic [PW_W-1:0]   base;
   logic [CHUNK-1:0]  x_chunk;
   logic [CHUNK-1:0]  y_chunk;
   logic [CHUNK:0]    slice;
   logic [PW-1:0]     res_next;

   assign base    = PW_W'(int'(idx) * CHUNK);
   assign x_chunk = x_reg[base +: CHUNK];
   assign y_chunk = y_reg[base +: CHUNK];
   assign slice   = {1'b0, x_chunk} + {1'b0, y_chunk} + {{CHUNK{1'b0}}, carry};

   // Result register with the current slice merged in; used both for the
   // running accumulation and for the final Sum_out capture on DONE entry.
   always_comb begin
      res_next = res_reg;
      res_next[base +: CHUNK] = slice[CHUNK-1:0];
   end

   // Padding bits above BIT_LEN+2 are always zero and never reach Sum_out.
   generate
      if (PW > W) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^res_next[PW-1:W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         Sum_out   <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         x_reg     <= '0;
         y_reg     <= '0;
         res_reg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               // Handshake requires the registered in_ready, so the first
               // cycle after reset never accepts.
               if (in_valid && in_ready) begin
                  x_reg    <= PW'(S_in);
                  y_reg    <= PW'({C_in, 1'b0});
                  carry    <= 1'b0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               res_reg <= res_next;
               carry   <= slice[CHUNK];
               if (idx == IDX_W'(NUM_CHUNKS - 1)) begin
                  // Final carry out is always zero: W bits hold S + 2C exactly.
                  Sum_out   <= res_next[W-1:0];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_resolver.sv
// tb/tb_csa_resolver.sv - self-checking bench for csa_resolver

module tb_csa_resolver;

   localparam int BIT_LEN    = 19;
   localparam int CHUNK      = 8;
   localparam int NUM_CHUNKS = (BIT_LEN + 2 + CHUNK - 1) / CHUNK;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [BIT_LEN-1:0] S_in;
   logic [BIT_LEN-1:0] C_in;
   logic               out_valid;
   logic               out_ready;
   logic [BIT_LEN+1:0] Sum_out;

   int checks = 0;
   int errors = 0;

   csa_resolver #(.BIT_LEN(BIT_LEN), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .S_in      (S_in),
      .C_in      (C_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum_out   (Sum_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BIT_LEN-1:0] s;
      logic [BIT_LEN-1:0] c;
      logic [BIT_LEN+1:0] exp;
      int                 hold;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [BIT_LEN+1:0] model(input logic [BIT_LEN-1:0] s, input logic [BIT_LEN-1:0] c);
      longint r;
      r = longint'(s) + 2 * longint'(c);
      return r[BIT_LEN+1:0];
   endfunction

   // One full transaction: wait for in_ready, present the pair for one edge,
   // scramble the inputs, measure latency, optionally stall, then retire.
   task automatic do_op(input string name, input logic [BIT_LEN-1:0] s, input logic [BIT_LEN-1:0] c,
                        input logic [BIT_LEN+1:0] exp, input int hold);
      int lat;
      int wt;
      logic [BIT_LEN+1:0] first;
      wt = 0;
      while (!in_ready && wt < 50) begin
         tick();
         wt++;
      end
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      S_in      = s;
      C_in      = c;
      tick();
      in_valid  = 1'b0;
      S_in      = BIT_LEN'($urandom);
      C_in      = BIT_LEN'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'(NUM_CHUNKS));
      chk({name, "_sum"}, 64'(Sum_out), 64'(exp));
      first = Sum_out;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
         chk({name, "_hold_sum"}, 64'(Sum_out), 64'(first));
      end
      out_ready = 1'b1;
      tick();
      chk({name, "_retire_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_retire_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      vecs[0] = '{s: 19'h44998, c: 19'h5F7ED, exp: 21'h103972, hold: 0};
      vecs[1] = '{s: 19'h7FFFF, c: 19'h7FFFF, exp: 21'h17FFFD, hold: 0};
      vecs[2] = '{s: 19'h000FF, c: 19'h00001, exp: 21'h000101, hold: 0};
      vecs[3] = '{s: 19'h00000, c: 19'h00000, exp: 21'h000000, hold: 1};
      vecs[4] = '{s: 19'h7FFFF, c: 19'h00000, exp: 21'h07FFFF, hold: 0};
      vecs[5] = '{s: 19'h00000, c: 19'h7FFFF, exp: 21'h0FFFFE, hold: 2};
      vecs[6] = '{s: 19'h00080, c: 19'h00040, exp: 21'h000100, hold: 0};
      vecs[7] = '{s: 19'h0FFFF, c: 19'h00001, exp: 21'h010001, hold: 0};

      // Reset with junk on the inputs.
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      S_in      = 19'h5A5A5;
      C_in      = 19'h3C3C3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_in_ready", 64'(in_ready), 64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_sum", 64'(Sum_out), 64'd0);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].exp, vecs[i].hold);
      end

      // Backpressure with a second in_valid pulse that must be ignored.
      in_valid  = 1'b1;
      S_in      = 19'h00001;
      C_in      = 19'h00002;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      begin
         int lat;
         lat = 0;
         while (!out_valid && lat < 20) begin
            tick();
            lat++;
         end
         chk("bp_latency", 64'(lat), 64'(NUM_CHUNKS));
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            in_valid = 1'b1;
            S_in     = 19'h11111;
            C_in     = 19'h22222;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_sum", 64'(Sum_out), 64'h5);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_no_second_op", 64'(out_valid), 64'd0);
      end

      // Reset in the second RUN cycle aborts the operation.
      in_valid = 1'b1;
      S_in     = 19'h12345;
      C_in     = 19'h00F0F;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_sum", 64'(Sum_out), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_valid", 64'(out_valid), 64'd0);
      end
      do_op("after_abort", 19'h0, 19'h0, 21'h0, 0);

      // Randomized operands with random stalls.
      for (int n = 0; n < 40; n++) begin
         logic [BIT_LEN-1:0] rs;
         logic [BIT_LEN-1:0] rc;
         rs = BIT_LEN'($urandom);
         rc = BIT_LEN'($urandom);
         if (n % 8 == 0) rs = '1;
         if (n % 8 == 1) rc = '1;
         do_op($sformatf("rnd%0d", n), rs, rc, model(rs, rc), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
